// File: rtl/vx_raster_dispatch_pkg.sv
// Shared record layout and dispatch sequencer states for the raster dispatch block.
package vx_raster_dispatch_pkg;

  localparam int VX_RASTER_DIM_BITS = 11;
  localparam int RASTER_DATA_BITS   = 32;
  localparam int VX_RASTER_PID_BITS = 16;
  localparam int REC_W = 2 * VX_RASTER_DIM_BITS + 9 * RASTER_DATA_BITS + VX_RASTER_PID_BITS;

  typedef struct packed {
    logic [VX_RASTER_DIM_BITS-1:0]             xloc;
    logic [VX_RASTER_DIM_BITS-1:0]             yloc;
    logic [2:0][2:0][RASTER_DATA_BITS-1:0]     edges;
    logic [VX_RASTER_PID_BITS-1:0]             pid;
  } raster_rec_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ARM,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } dispatch_state_e;

endpackage

// File: rtl/vx_raster_dispatch_credit_rr.sv
// Per-slice credit tracking and round-robin slice selection for record dispatch.
module vx_raster_dispatch_credit_rr #(
  parameter int    NUM_SLICES    = 4,
  parameter int    SLICE_CREDITS = 4,
  parameter string INSTANCE_ID   = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SLICES-1:0] ready_i,
  input  logic [NUM_SLICES-1:0] retire_i,
  input  logic                  fire_i,
  output logic [NUM_SLICES-1:0] grant_o,
  output logic                  any_eligible_o,
  output logic                  all_idle_o
);

  localparam int CW = $clog2(SLICE_CREDITS + 1);
  localparam int PW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(SLICE_CREDITS);

  logic [NUM_SLICES-1:0] eligible;
  logic [NUM_SLICES-1:0] outstanding;
  logic [PW-1:0]         rr_q;
  logic [PW-1:0]         grant_idx;

  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    return PW'(sum % NUM_SLICES);
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
      logic [CW-1:0] credit_q;
      logic          inc;
      logic          dec;

      // A retire against an empty counter is ignored so the count never underflows.
      assign inc = fire_i && grant_o[gi];
      assign dec = retire_i[gi] && (credit_q != '0);

      assign eligible[gi]    = ready_i[gi] && (credit_q < CRED_MAX);
      assign outstanding[gi] = (credit_q != '0);

      always_ff @(posedge clk) begin
        if (reset) begin
          credit_q <= '0;
        end else if (inc && !dec) begin
          credit_q <= credit_q + 1'b1;
        end else if (dec && !inc) begin
          credit_q <= credit_q - 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset && retire_i[gi]) begin
          assert (credit_q != '0)
            else $error("%s: retire on slice %0d with no outstanding credit", INSTANCE_ID, gi);
        end
      end
    end
  endgenerate

  // First eligible slice at or after the pointer wins.
  always_comb begin
    grant_o        = '0;
    grant_idx      = '0;
    any_eligible_o = 1'b0;
    for (int k = 0; k < NUM_SLICES; k++) begin
      if (!any_eligible_o && eligible[rr_index(rr_q, k)]) begin
        any_eligible_o = 1'b1;
        grant_idx      = rr_index(rr_q, k);
      end
    end
    if (any_eligible_o) begin
      grant_o[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= '0;
    end else if (fire_i) begin
      rr_q <= rr_index(grant_idx, 1);
    end
  end

  assign all_idle_o = ~|outstanding;

endmodule

// File: rtl/vx_raster_dispatch.sv
// Frame sequencer: starts the memory unit, drains its record stream to raster slices, signals completion.
module vx_raster_dispatch
  import vx_raster_dispatch_pkg::*;
#(
  parameter int    NUM_SLICES    = 4,
  parameter int    SLICE_CREDITS = 4,
  parameter string INSTANCE_ID   = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           rec_count_o,
  output logic                  mem_start_o,
  input  logic                  mem_busy_i,
  input  logic                  in_valid_i,
  input  raster_rec_t           in_data_i,
  output logic                  in_ready_o,
  output logic [NUM_SLICES-1:0] slice_valid_o,
  output raster_rec_t           slice_data_o,
  input  logic [NUM_SLICES-1:0] slice_ready_i,
  input  logic [NUM_SLICES-1:0] slice_retire_i
);

  dispatch_state_e       state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  mem_start_q;
  logic [31:0]           rec_count_q;
  logic [NUM_SLICES-1:0] grant;
  logic                  any_eligible;
  logic                  all_idle;
  logic                  fire;

  vx_raster_dispatch_credit_rr #(
    .NUM_SLICES    (NUM_SLICES),
    .SLICE_CREDITS (SLICE_CREDITS),
    .INSTANCE_ID   (INSTANCE_ID)
  ) u_credit_rr (
    .clk            (clk),
    .reset          (reset),
    .ready_i        (slice_ready_i),
    .retire_i       (slice_retire_i),
    .fire_i         (fire),
    .grant_o        (grant),
    .any_eligible_o (any_eligible),
    .all_idle_o     (all_idle)
  );

  assign in_ready_o    = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && any_eligible;
  assign fire          = in_valid_i && in_ready_o;
  assign slice_valid_o = grant & {NUM_SLICES{fire}};
  assign slice_data_o  = in_data_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_start_q <= 1'b0;
      rec_count_q <= '0;
    end else begin
      done_q      <= 1'b0;
      mem_start_q <= 1'b0;
      if (fire) begin
        rec_count_q <= rec_count_q + 32'd1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q     <= ST_START;
            busy_q      <= 1'b1;
            mem_start_q <= 1'b1;
            rec_count_q <= '0;
          end
        end
        ST_START: state_q <= ST_ARM;
        // A memory unit that never raises busy produced an empty frame.
        ST_ARM:   state_q <= mem_busy_i ? ST_RUN : ST_DRAIN;
        ST_RUN: begin
          if (!mem_busy_i && !in_valid_i) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (all_idle && !in_valid_i) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign mem_start_o = mem_start_q;
  assign rec_count_o = rec_count_q;

endmodule
